// File: rtl/fetch_pkg.sv
// Shared constants and the fetch queue entry layout for the fetch front end.
// Latency: n/a (types only). Backpressure: n/a.
// The entry struct here is the XLEN=32 layout; the stage builds the same shape for its own XLEN.
package fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam int          PC_STEP   = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with synchronous flush and full/empty/count status.
// Latency: a pushed word reaches the head the cycle after the push (no bypass).
// Backpressure: a push while full is taken only when a pop frees a slot in the same cycle.
module fetch_fifo #(
  parameter int  WIDTH = 32,
  parameter int  DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths (pending-PC tracker) also work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: credit-limited imem requests, in-order responses buffered in a DEPTH-entry decode queue.
// Latency: response to dec_valid is 1 cycle; a redirect leaves the queue empty on the following cycle.
// Backpressure: issue stalls on MAX_OUTST or queue credit; dec_ready low holds the head. FETCH_PERF_EN adds perf counters.
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [XLEN-1:0]    dec_pc,
  output logic [XLEN-1:0]    dec_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_dropped
`endif
);

  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int QCW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_cnt;
  logic            req_fire;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            q_push;
  logic            dec_fire;

  entry_t          q_push_dat;
  entry_t          q_head;
  entry_t          last_head;
  entry_t          dec_head;
  logic            q_full;
  logic            q_empty;
  logic [QCW-1:0]  q_count;

  logic [XLEN-1:0] pend_pc;
  logic            pend_full;
  logic            pend_empty;
  logic [OW-1:0]   pend_count;

  // Stale responses are counted in outstanding, so credit stays conservative while draining them.
  assign imem_req_valid = !rst && !redirect_valid
                          && (int'(outstanding) < MAX_OUTST)
                          && ((int'(q_count) + int'(outstanding)) < DEPTH);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0);
  assign q_push   = rsp_keep && !redirect_valid;

  assign q_push_dat = '{instr:    imem_rsp_data,
                        pc:       pend_pc,
                        pc_plus4: pend_pc + XLEN'(PC_STEP)};

  assign dec_valid    = !q_empty;
  assign dec_fire     = dec_valid && dec_ready;
  assign dec_head     = q_empty ? last_head : q_head;
  assign dec_instr    = dec_head.instr;
  assign dec_pc       = dec_head.pc;
  assign dec_pc_plus4 = dec_head.pc_plus4;

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (q_push),
    .push_dat (q_push_dat),
    .pop      (dec_fire),
    .head_dat (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  // PCs of live requests only; entries for squashed requests are flushed and tracked by drop_cnt.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTST)
  ) u_pend (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (req_fire),
    .push_dat (fetch_pc),
    .pop      (rsp_keep),
    .head_dat (pend_pc),
    .full     (pend_full),
    .empty    (pend_empty),
    .count    (pend_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      last_head   <= '0;
    end else begin
      if (redirect_valid)  fetch_pc <= redirect_pc;
      else if (req_fire)   fetch_pc <= fetch_pc + XLEN'(PC_STEP);

      outstanding <= outstanding + OW'(req_fire) - OW'(imem_rsp_valid);

      // Everything still in flight after this cycle belongs to the old path.
      if (redirect_valid)  drop_cnt <= outstanding - OW'(imem_rsp_valid);
      else if (rsp_drop)   drop_cnt <= drop_cnt - OW'(1);

      if (!q_empty) last_head <= q_head;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (q_push) perf_fetched <= perf_fetched + 32'd1;
      if (imem_rsp_valid && !q_push) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

  assert property (@(posedge clk) disable iff (rst) !(q_push && q_full));
  assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid && outstanding == '0));
  assert property (@(posedge clk) disable iff (rst) !(req_fire && pend_full));
  assert property (@(posedge clk) disable iff (rst) !(rsp_keep && pend_empty));
  assert property (@(posedge clk) disable iff (rst)
                   (int'(pend_count) + int'(drop_cnt)) == int'(outstanding));

endmodule
